fan_speed_ctrl: RTL and testbench
=================================

Name: fan_speed_ctrl

Overview:
Fan speed/mode controller that sits directly upstream of the PWM generator and drives its 32-bit duty input. It consumes single-cycle command pulses from the debounced button front-end or the IR decoder: speed cycle, off-timer cycle, and hard off. It produces a soft-ramped duty value, the current speed level, and off-timer status for display.

Parameters:
DUTY_STEP, 128, duty resolution of downstream PWM; duty output range 0..DUTY_STEP-1
DUTY_L1, 40, target duty for speed level 1
DUTY_L2, 80, target duty for speed level 2
DUTY_L3, 127, target duty for speed level 3 (must be <= DUTY_STEP-1)
RAMP_TICK_CYCLES, 100_000, clk cycles per one-count duty ramp step (1 ms @100 MHz)
TIMER_UNIT_CYCLES, 6_000_000_000, clk cycles per off-timer unit (1 min @100 MHz); counter width derived via $clog2

Ports:
clk  input  1  system clock
reset_p  input  1  reset, asynchronous, active-high
speed_btn  input  1  1-cycle pulse: advance speed level
timer_btn  input  1  1-cycle pulse: advance off-timer selection
off_btn  input  1  1-cycle pulse: immediate stop
duty  output  32  duty to PWM generator, bits [31:$clog2(DUTY_STEP)] always 0
speed_level  output  2  0=off, 1..3 current level
timer_sel  output  2  0=none, 1=1 unit, 2=3 units, 3=5 units
timer_remain  output  3  remaining whole units, 0 when timer_sel=0
ramp_busy  output  1  high while duty != target duty

Behaviour:
- Reset (async, reset_p=1): duty=0, speed_level=0, timer_sel=0, timer_remain=0, ramp_busy=0, both tick counters=0, state OFF.
- States: OFF (speed_level=0), RUN (speed_level 1..3). All registered; outputs update the cycle after the causing pulse.
- Command priority, same cycle: off_btn > timer expiry > speed_btn > timer_btn. Lower-priority events in that cycle are dropped, not queued.
- speed_btn: OFF->RUN, level 1; RUN level 1->2->3. Level 3->OFF (level 0), which also clears timer_sel/timer_remain.
- off_btn (any state): level 0, timer cleared, duty forced to 0 on next cycle (no ramp), ramp_busy=0.
- timer_btn in RUN: timer_sel cycles 0->1->2->3->0. timer_remain loads 0/1/3/5. Timer unit counter restarts at 0. Ignored in OFF.
- Timer: when timer_sel!=0, unit counter counts 0..TIMER_UNIT_CYCLES-1. At terminal count, timer_remain decrements. Decrement 1->0 = expiry: level 0, timer_sel 0, duty ramps down (not forced).
- Target duty: combinational map from level: 0->0, 1->DUTY_L1, 2->DUTY_L2, 3->DUTY_L3.
- Ramp tick: free-running counter 0..RAMP_TICK_CYCLES-1 from reset; tick pulse on terminal count. On tick: duty<target -> duty+1; duty>target -> duty-1; else hold. Exactly one count per tick, no overshoot.
- Target change mid-ramp: ramp continues from the current duty toward the new target; no restart of tick phase.
- ramp_busy = registered (duty != target), excluding the forced-off case.
- Reset mid-ramp/mid-timer: everything returns to reset values immediately.

Decomposition:
- Package fan_pkg: level encodings (LVL_OFF..LVL_3), timer table constants (TMR_UNITS_0/1/3/5), state enum {ST_OFF, ST_RUN}.
- One sub-module, fan_tick_gen: parametric modulo-N counter with sync clear and 1-cycle terminal-count pulse. Instantiated twice: ramp tick (never cleared) and timer unit (cleared on timer load/clear).

Test Plan:
(Bench uses RAMP_TICK_CYCLES=4, TIMER_UNIT_CYCLES=20, DUTY_L1=3, DUTY_L2=6, DUTY_L3=9.)
1. Reset, then one speed_btn -> speed_level=1 next cycle, ramp_busy=1; duty steps 0->1->2->3, one step every 4 clk; then ramp_busy=0.
2. From level 1 settled, speed_btn x3 spaced 100 clk -> levels 2, 3, 0; duty settles 6, then 9, then ramps down to 0; timer_sel stays 0.
3. Level 3 settled, off_btn -> duty=0 and speed_level=0 on next cycle, ramp_busy=0; later timer_btn in OFF -> timer_sel stays 0.
4. Level 2, timer_btn x2 -> timer_sel=2, timer_remain=3; after 60 clk remain=0, speed_level=0, timer_sel=0; duty ramps 6->0 over 24 clk.
5. speed_btn and off_btn in same cycle at level 1 -> level 0, duty 0 (off wins). speed_btn and timer_btn together -> level advances, timer_sel unchanged.
6. Assert reset_p mid-ramp (duty=4, target 9) -> all outputs 0 asynchronously; after release, no activity until the next pulse.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared encodings for the fan speed/mode controller: speed levels, off-timer
// unit table and the top-level run state.
package fan_pkg;

    localparam logic [1:0] LVL_OFF = 2'd0;
    localparam logic [1:0] LVL_1   = 2'd1;
    localparam logic [1:0] LVL_2   = 2'd2;
    localparam logic [1:0] LVL_3   = 2'd3;

    localparam logic [2:0] TMR_UNITS_0 = 3'd0;
    localparam logic [2:0] TMR_UNITS_1 = 3'd1;
    localparam logic [2:0] TMR_UNITS_3 = 3'd3;
    localparam logic [2:0] TMR_UNITS_5 = 3'd5;

    typedef enum logic {
        ST_OFF,
        ST_RUN
    } state_t;

    // Off-timer selection -> number of whole units loaded into the countdown.
    function automatic logic [2:0] timer_units(input logic [1:0] sel);
        logic [2:0] units;
        case (sel)
            2'd1:    units = TMR_UNITS_1;
            2'd2:    units = TMR_UNITS_3;
            2'd3:    units = TMR_UNITS_5;
            default: units = TMR_UNITS_0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/fan_speed_ctrl_if.sv
// Command pulses into and display/PWM status out of the fan speed controller.
interface fan_speed_ctrl_if;

    logic        speed_btn;
    logic        timer_btn;
    logic        off_btn;
    logic [31:0] duty;
    logic [1:0]  speed_level;
    logic [1:0]  timer_sel;
    logic [2:0]  timer_remain;
    logic        ramp_busy;

    modport master (
        output speed_btn, timer_btn, off_btn,
        input  duty, speed_level, timer_sel, timer_remain, ramp_busy
    );

    modport slave (
        input  speed_btn, timer_btn, off_btn,
        output duty, speed_level, timer_sel, timer_remain, ramp_busy
    );

endinterface

// File: rtl/fan_tick_gen.sv
// Modulo-N cycle counter with synchronous clear; tick_c is high for the one
// cycle in which the count sits at its terminal value N-1.
module fan_tick_gen #(
    parameter longint unsigned N = 64'd4
) (
    input  logic clk,
    input  logic reset_p,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned W    = (N > 64'd1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 64'd1);

    logic [W-1:0] cnt_q;

    assign tick_c = (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/fan_speed_ctrl.sv
// Fan speed/mode controller feeding the PWM duty input: speed level cycling,
// off-timer countdown and a one-count-per-tick soft ramp of the duty value.
module fan_speed_ctrl
    import fan_pkg::*;
#(
    parameter int unsigned     DUTY_STEP         = 128,
    parameter int unsigned     DUTY_L1           = 40,
    parameter int unsigned     DUTY_L2           = 80,
    parameter int unsigned     DUTY_L3           = 127,
    parameter int unsigned     RAMP_TICK_CYCLES  = 100_000,
    parameter longint unsigned TIMER_UNIT_CYCLES = 64'd6_000_000_000
) (
    input  logic            clk,
    input  logic            reset_p,
    fan_speed_ctrl_if.slave bus
);

    localparam int unsigned DW = $clog2(DUTY_STEP);

    state_t        state_q, state_d;
    logic [1:0]    level_q, level_d;
    logic [1:0]    sel_q, sel_d;
    logic [2:0]    remain_q, remain_d;
    logic [DW-1:0] duty_q, duty_d;
    logic          busy_q, busy_d;

    logic          ramp_tick_c;
    logic          unit_raw_c;
    logic          unit_tick_c;
    logic          tmr_load_c;
    logic          tmr_clear_c;
    logic          force_off_c;
    logic [DW-1:0] target_c;

    function automatic logic [DW-1:0] target_of(input logic [1:0] lvl);
        logic [DW-1:0] t;
        case (lvl)
            LVL_1:   t = DW'(DUTY_L1);
            LVL_2:   t = DW'(DUTY_L2);
            LVL_3:   t = DW'(DUTY_L3);
            default: t = '0;
        endcase
        return t;
    endfunction

    fan_tick_gen #(.N(64'(RAMP_TICK_CYCLES))) u_ramp_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .clear   (1'b0),
        .tick_c  (ramp_tick_c)
    );

    // Unit counter idles at 0 whenever no timer is armed, and restarts on every load.
    assign tmr_clear_c = tmr_load_c || (sel_q == 2'd0);

    fan_tick_gen #(.N(TIMER_UNIT_CYCLES)) u_unit_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .clear   (tmr_clear_c),
        .tick_c  (unit_raw_c)
    );

    assign unit_tick_c = unit_raw_c && (sel_q != 2'd0);
    assign target_c    = target_of(level_q);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q  <= ST_OFF;
            level_q  <= LVL_OFF;
            sel_q    <= 2'd0;
            remain_q <= 3'd0;
            duty_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            sel_q    <= sel_d;
            remain_q <= remain_d;
            duty_q   <= duty_d;
            busy_q   <= busy_d;
        end
    end

    // Priority: off > timer expiry > speed > timer select; losers are dropped.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        sel_d       = sel_q;
        remain_d    = remain_q;
        duty_d      = duty_q;
        tmr_load_c  = 1'b0;
        force_off_c = 1'b0;

        if (unit_tick_c && (remain_q > 3'd1)) begin
            remain_d = remain_q - 3'd1;
        end

        if (bus.off_btn) begin
            state_d     = ST_OFF;
            level_d     = LVL_OFF;
            sel_d       = 2'd0;
            remain_d    = TMR_UNITS_0;
            force_off_c = 1'b1;
        end else if (unit_tick_c && (remain_q == 3'd1)) begin
            state_d  = ST_OFF;
            level_d  = LVL_OFF;
            sel_d    = 2'd0;
            remain_d = TMR_UNITS_0;
        end else if (bus.speed_btn) begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_RUN;
                    level_d = LVL_1;
                end
                default: begin
                    if (level_q == LVL_3) begin
                        state_d  = ST_OFF;
                        level_d  = LVL_OFF;
                        sel_d    = 2'd0;
                        remain_d = TMR_UNITS_0;
                    end else begin
                        level_d = level_q + 2'd1;
                    end
                end
            endcase
        end else if (bus.timer_btn && (state_q == ST_RUN)) begin
            sel_d      = sel_q + 2'd1;
            remain_d   = timer_units(sel_q + 2'd1);
            tmr_load_c = 1'b1;
        end

        // Ramp steps toward the target of the level in force this cycle.
        if (force_off_c) begin
            duty_d = '0;
        end else if (ramp_tick_c) begin
            if (duty_q < target_c) begin
                duty_d = duty_q + DW'(1);
            end else if (duty_q > target_c) begin
                duty_d = duty_q - DW'(1);
            end
        end

        busy_d = (duty_d != target_of(level_d));
    end

    assign bus.duty         = 32'(duty_q);
    assign bus.speed_level  = level_q;
    assign bus.timer_sel    = sel_q;
    assign bus.timer_remain = remain_q;
    assign bus.ramp_busy    = busy_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Self-checking bench for fan_speed_ctrl: directed scenarios plus random
// command pulses, all compared against a cycle-count based reference model.
module tb_fan_speed_ctrl;

    localparam int RT = 4;
    localparam int TU = 20;
    localparam int L1 = 3;
    localparam int L2 = 6;
    localparam int L3 = 9;

    logic clk = 1'b0;
    logic reset_p = 1'b1;

    fan_speed_ctrl_if bus();

    fan_speed_ctrl #(
        .DUTY_STEP         (128),
        .DUTY_L1           (L1),
        .DUTY_L2           (L2),
        .DUTY_L3           (L3),
        .RAMP_TICK_CYCLES  (RT),
        .TIMER_UNIT_CYCLES (64'(TU))
    ) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: whole-number view of the outputs plus cycle bookkeeping.
    int m_level, m_sel, m_remain, m_duty, m_busy;
    int m_cycle, m_unit_start;

    logic [38:0] got;
    assign got = {bus.duty, bus.speed_level, bus.timer_sel, bus.timer_remain, bus.ramp_busy};

    function automatic int tgt(input int lvl);
        case (lvl)
            1: return L1;
            2: return L2;
            3: return L3;
            default: return 0;
        endcase
    endfunction

    function automatic int units(input int sel);
        case (sel)
            1: return 1;
            2: return 3;
            3: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [38:0] model_vec();
        return {32'(m_duty), 2'(m_level), 2'(m_sel), 3'(m_remain), 1'(m_busy)};
    endfunction

    task automatic model_reset();
        m_level = 0; m_sel = 0; m_remain = 0; m_duty = 0; m_busy = 0;
        m_cycle = 0; m_unit_start = 0;
    endtask

    // One clock: present pulses, advance the model by the stated rules, sample after the edge.
    task automatic cycle(input bit sp, input bit tm, input bit of);
        int nl, ns, nr, nd, t;
        bit rt, ut;
        bus.speed_btn = sp;
        bus.timer_btn = tm;
        bus.off_btn   = of;
        rt = (m_cycle % RT) == RT - 1;
        ut = (m_sel != 0) && (((m_cycle - m_unit_start) % TU) == TU - 1);
        t  = tgt(m_level);
        nl = m_level; ns = m_sel; nr = m_remain; nd = m_duty;
        if (ut && m_remain > 1) nr = m_remain - 1;
        if (of) begin
            nl = 0; ns = 0; nr = 0;
        end else if (ut && m_remain == 1) begin
            nl = 0; ns = 0; nr = 0;
        end else if (sp) begin
            nl = (m_level + 1) % 4;
            if (nl == 0) begin ns = 0; nr = 0; end
        end else if (tm && m_level != 0) begin
            ns = (m_sel + 1) % 4;
            nr = units(ns);
            m_unit_start = m_cycle + 1;
        end
        if (of) nd = 0;
        else if (rt && nd < t) nd = nd + 1;
        else if (rt && nd > t) nd = nd - 1;
        @(posedge clk);
        m_level = nl; m_sel = ns; m_remain = nr; m_duty = nd;
        m_busy  = (nd != tgt(nl)) ? 1 : 0;
        m_cycle++;
        #1;
        bus.speed_btn = 1'b0;
        bus.timer_btn = 1'b0;
        bus.off_btn   = 1'b0;
    endtask

    task automatic do_reset();
        bus.speed_btn = 1'b0;
        bus.timer_btn = 1'b0;
        bus.off_btn   = 1'b0;
        reset_p = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_p = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (got !== 39'd0) begin
            errors++;
            $display("FAIL reset_state got=%h want=0", got);
        end
        repeat (10) begin
            cycle(0, 0, 0);
            checks++;
            if (got !== model_vec()) begin
                errors++;
                $display("FAIL reset_idle c%0d got=%h want=%h", m_cycle, got, model_vec());
            end
        end
    endtask

    task automatic test_ramp_up();
        int changes = 0;
        logic [31:0] prev;
        cycle(1, 0, 0);
        checks++;
        if (bus.speed_level !== 2'd1 || bus.ramp_busy !== 1'b1 || bus.duty !== 32'd0) begin
            errors++;
            $display("FAIL ramp_start got lvl=%0d busy=%0d duty=%0d want 1 1 0",
                     bus.speed_level, bus.ramp_busy, bus.duty);
        end
        prev = bus.duty;
        repeat (20) begin
            cycle(0, 0, 0);
            if (bus.duty != prev) changes++;
            prev = bus.duty;
            checks++;
            if (got !== model_vec()) begin
                errors++;
                $display("FAIL ramp_up c%0d got=%h want=%h", m_cycle, got, model_vec());
            end
        end
        checks++;
        if (bus.duty !== 32'd3 || bus.ramp_busy !== 1'b0 || changes != 3) begin
            errors++;
            $display("FAIL ramp_settle got duty=%0d busy=%0d steps=%0d want 3 0 3",
                     bus.duty, bus.ramp_busy, changes);
        end
    endtask

    task automatic test_speed_cycle();
        int exp_lvl[3]  = '{2, 3, 0};
        int exp_duty[3] = '{6, 9, 0};
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0);
            checks++;
            if (bus.speed_level !== 2'(exp_lvl[i])) begin
                errors++;
                $display("FAIL speed_level[%0d] got=%0d want=%0d", i, bus.speed_level, exp_lvl[i]);
            end
            repeat (99) begin
                cycle(0, 0, 0);
                checks++;
                if (got !== model_vec()) begin
                    errors++;
                    $display("FAIL speed_cycle c%0d got=%h want=%h", m_cycle, got, model_vec());
                end
            end
            checks++;
            if (bus.duty !== 32'(exp_duty[i]) || bus.timer_sel !== 2'd0 || bus.ramp_busy !== 1'b0) begin
                errors++;
                $display("FAIL speed_settle[%0d] got duty=%0d sel=%0d busy=%0d want %0d 0 0",
                         i, bus.duty, bus.timer_sel, bus.ramp_busy, exp_duty[i]);
            end
        end
    endtask

    task automatic test_off();
        repeat (3) cycle(1, 0, 0);
        repeat (60) cycle(0, 0, 0);
        checks++;
        if (bus.duty !== 32'd9 || bus.speed_level !== 2'd3) begin
            errors++;
            $display("FAIL off_pre got duty=%0d lvl=%0d want 9 3", bus.duty, bus.speed_level);
        end
        cycle(0, 0, 1);
        checks++;
        if (got !== 39'd0) begin
            errors++;
            $display("FAIL off_force got=%h want=0", got);
        end
        repeat (5) cycle(0, 0, 0);
        cycle(0, 1, 0);
        checks++;
        if (bus.timer_sel !== 2'd0 || got !== model_vec()) begin
            errors++;
            $display("FAIL off_timer_ignored got=%h want=%h", got, model_vec());
        end
    endtask

    task automatic test_timer();
        repeat (2) cycle(1, 0, 0);
        repeat (40) cycle(0, 0, 0);
        checks++;
        if (bus.duty !== 32'd6 || bus.speed_level !== 2'd2) begin
            errors++;
            $display("FAIL timer_pre got duty=%0d lvl=%0d want 6 2", bus.duty, bus.speed_level);
        end
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        checks++;
        if (bus.timer_sel !== 2'd2 || bus.timer_remain !== 3'd3) begin
            errors++;
            $display("FAIL timer_load got sel=%0d rem=%0d want 2 3", bus.timer_sel, bus.timer_remain);
        end
        repeat (60) begin
            cycle(0, 0, 0);
            checks++;
            if (got !== model_vec()) begin
                errors++;
                $display("FAIL timer_count c%0d got=%h want=%h", m_cycle, got, model_vec());
            end
        end
        checks++;
        if (bus.timer_remain !== 3'd0 || bus.speed_level !== 2'd0 || bus.timer_sel !== 2'd0
            || bus.duty !== 32'd6 || bus.ramp_busy !== 1'b1) begin
            errors++;
            $display("FAIL timer_expiry got=%h want lvl0 sel0 rem0 duty6 busy1", got);
        end
        repeat (24) cycle(0, 0, 0);
        checks++;
        if (bus.duty !== 32'd0 || bus.ramp_busy !== 1'b0) begin
            errors++;
            $display("FAIL timer_rampdown got duty=%0d busy=%0d want 0 0", bus.duty, bus.ramp_busy);
        end
    endtask

    task automatic test_same_cycle();
        cycle(1, 0, 0);
        repeat (6) cycle(0, 0, 0);
        cycle(1, 0, 1);
        checks++;
        if (bus.speed_level !== 2'd0 || bus.duty !== 32'd0 || got !== model_vec()) begin
            errors++;
            $display("FAIL same_off_wins got=%h want=%h", got, model_vec());
        end
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        checks++;
        if (bus.speed_level !== 2'd2 || bus.timer_sel !== 2'd0 || got !== model_vec()) begin
            errors++;
            $display("FAIL same_speed_wins got=%h want=%h", got, model_vec());
        end
    endtask

    task automatic test_reset_mid_ramp();
        int n = 0;
        cycle(0, 0, 1);
        repeat (3) cycle(1, 0, 0);
        while (m_duty != 4 && n < 100) begin
            cycle(0, 0, 0);
            n++;
        end
        checks++;
        if (bus.duty !== 32'd4 || bus.speed_level !== 2'd3 || got !== model_vec()) begin
            errors++;
            $display("FAIL midramp_pre got=%h want=%h", got, model_vec());
        end
        reset_p = 1'b1;
        #1;
        checks++;
        if (got !== 39'd0) begin
            errors++;
            $display("FAIL async_reset got=%h want=0", got);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_p = 1'b0;
        model_reset();
        repeat (30) cycle(0, 0, 0);
        checks++;
        if (got !== 39'd0) begin
            errors++;
            $display("FAIL post_reset_idle got=%h want=0", got);
        end
    endtask

    task automatic test_random();
        bit sp, tm, of;
        repeat (3000) begin
            sp = ($urandom % 16) == 0;
            tm = ($urandom % 10) == 0;
            of = ($urandom % 80) == 0;
            cycle(sp, tm, of);
            checks++;
            if (got !== model_vec()) begin
                errors++;
                $display("FAIL random c%0d got=%h want=%h", m_cycle, got, model_vec());
            end
        end
    endtask

    initial begin
        bus.speed_btn = 1'b0;
        bus.timer_btn = 1'b0;
        bus.off_btn   = 1'b0;
        model_reset();
        test_reset();
        test_ramp_up();
        test_speed_cycle();
        test_off();
        test_timer();
        test_same_cycle();
        test_reset_mid_ramp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
